fft_res_buf_ctrl: RTL and testbench

//  Ping-pong scheduler for the FFT result MRAM buffer (two banks of transform_length/2 words).

---
 rtl/fft_res_buf_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_fft_res_buf_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_res_buf_ctrl.sv
// fft_res_buf_ctrl: ping-pong scheduler for the FFT result MRAM.
// Two banks of transform_length/2 words. The write side fills the free bank with
// one frame of FFT output. The read side drains full banks under out_ready
// backpressure, with valid/sop/eop framing delayed to match the RAM read latency.
// Optional feature macro: FFT_RES_FRAME_CNT_EN enables the frames_wr/rd/drop counters.
// When the macro is undefined those three outputs are tied to zero.
module fft_res_buf_ctrl #(
  parameter int unsigned transform_length      = 32768,
  parameter int unsigned log2_transform_length = 15,
  parameter int unsigned rd_latency            = 1
) (
  input  logic                             clk_fft,
  input  logic                             reset,
  input  logic                             master_source_sop,
  input  logic                             master_source_ena,
  input  logic                             out_ready,
  input  logic                             clear_err,
  output logic                             mram_wren,
  output logic [log2_transform_length-1:0] mram_writeadd,
  output logic                             mram_rden,
  output logic [log2_transform_length-1:0] mram_readadd,
  output logic                             out_valid,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [1:0]                       bank_full,
  output logic                             overflow_err,
  output logic                             short_frame_err,
  output logic [15:0]                      frames_wr,
  output logic [15:0]                      frames_rd,
  output logic [15:0]                      frames_drop
);

  localparam int unsigned FRAME_LEN = transform_length / 2;
  localparam int unsigned OFF_W     = log2_transform_length - 1;
  localparam int unsigned CNT_W     = 16;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
  typedef enum logic       {R_IDLE, R_READ}         rstate_t;

  wstate_t          wstate;
  rstate_t          rstate;
  logic             wbank;
  logic             rbank;
  logic [OFF_W-1:0] woffset;
  logic [OFF_W-1:0] roffset;

  logic             w_start;
  logic             w_accept;
  logic             w_drop;
  logic             w_short;
  logic [OFF_W-1:0] w_off;
  logic             wr_done;
  logic             rd_done;
  logic             rd_first;

  logic [rd_latency-1:0] v_pipe;
  logic [rd_latency-1:0] s_pipe;
  logic [rd_latency-1:0] e_pipe;

  // Write-side decode: strobes are combinational to the input sample cycle
  always_comb begin
    w_start   = master_source_sop & master_source_ena;
    w_accept  = 1'b0;
    w_drop    = 1'b0;
    w_short   = 1'b0;
    mram_wren = 1'b0;
    w_off     = '0;
    if (wstate == W_FILL) begin
      mram_wren = master_source_ena;
      w_short   = w_start;
      w_off     = w_start ? '0 : woffset;
    end else if (w_start) begin
      w_accept  = ~bank_full[wbank];
      w_drop    = bank_full[wbank];
      mram_wren = ~bank_full[wbank];
    end
    // An early sop restarts at offset 0, so it can never complete the bank
    wr_done       = mram_wren & (w_off == LAST_OFF) & ~w_short;
    mram_writeadd = {wbank, w_off};
  end

  // Read-side decode: a read is issued whenever the consumer is ready mid-frame
  always_comb begin
    mram_rden    = (rstate == R_READ) & out_ready;
    rd_done      = mram_rden & (roffset == LAST_OFF);
    rd_first     = mram_rden & (roffset == '0);
    mram_readadd = {rbank, roffset};
  end

  // Write FSM: fill the free bank, restart on early sop, discard frames when both banks are full
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      wstate  <= W_IDLE;
      wbank   <= 1'b0;
      woffset <= '0;
    end else begin
      case (wstate)
        W_FILL: begin
          if (master_source_ena) begin
            if (w_short) begin
              woffset <= OFF_W'(1);
            end else if (wr_done) begin
              woffset <= '0;
              wbank   <= ~wbank;
              wstate  <= W_IDLE;
            end else begin
              woffset <= woffset + OFF_W'(1);
            end
          end
        end
        default: begin
          if (w_accept) begin
            woffset <= OFF_W'(1);
            wstate  <= W_FILL;
          end else if (w_drop) begin
            wstate  <= W_DROP;
          end
        end
      endcase
    end
  end

  // Read FSM: drain the current read bank word by word, one idle cycle between frames
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      rstate  <= R_IDLE;
      rbank   <= 1'b0;
      roffset <= '0;
    end else begin
      case (rstate)
        R_READ: begin
          if (rd_done) begin
            roffset <= '0;
            rbank   <= ~rbank;
            rstate  <= R_IDLE;
          end else if (mram_rden) begin
            roffset <= roffset + OFF_W'(1);
          end
        end
        default: begin
          roffset <= '0;
          if (bank_full[rbank]) rstate <= R_READ;
        end
      endcase
    end
  end

  // Full flags: set by a completed write, cleared by a drained read (never the same bank at once)
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      bank_full <= 2'b00;
    end else begin
      bank_full[0] <= (wr_done & ~wbank) | (bank_full[0] & ~(rd_done & ~rbank));
      bank_full[1] <= (wr_done &  wbank) | (bank_full[1] & ~(rd_done &  rbank));
    end
  end

  // Sticky error flags; clear_err wins over a same-cycle set
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      overflow_err    <= 1'b0;
      short_frame_err <= 1'b0;
    end else if (clear_err) begin
      overflow_err    <= 1'b0;
      short_frame_err <= 1'b0;
    end else begin
      overflow_err    <= overflow_err | w_drop;
      short_frame_err <= short_frame_err | w_short;
    end
  end

  // Framing delay line matching the RAM read latency
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      v_pipe <= '0;
      s_pipe <= '0;
      e_pipe <= '0;
    end else begin
      v_pipe[0] <= mram_rden;
      s_pipe[0] <= rd_first;
      e_pipe[0] <= rd_done;
      for (int i = 1; i < int'(rd_latency); i++) begin
        v_pipe[i] <= v_pipe[i-1];
        s_pipe[i] <= s_pipe[i-1];
        e_pipe[i] <= e_pipe[i-1];
      end
    end
  end

  assign out_valid = v_pipe[rd_latency-1];
  assign out_sop   = s_pipe[rd_latency-1];
  assign out_eop   = e_pipe[rd_latency-1];

`ifdef FFT_RES_FRAME_CNT_EN
  logic [CNT_W-1:0] cnt_wr;
  logic [CNT_W-1:0] cnt_rd;
  logic [CNT_W-1:0] cnt_drop;

  // Frame statistics, wrapping, cleared by reset only
  always_ff @(posedge clk_fft) begin
    if (reset) begin
      cnt_wr   <= '0;
      cnt_rd   <= '0;
      cnt_drop <= '0;
    end else begin
      if (wr_done) cnt_wr   <= cnt_wr + CNT_W'(1);
      if (rd_done) cnt_rd   <= cnt_rd + CNT_W'(1);
      if (w_drop)  cnt_drop <= cnt_drop + CNT_W'(1);
    end
  end

  assign frames_wr   = cnt_wr;
  assign frames_rd   = cnt_rd;
  assign frames_drop = cnt_drop;
`else
  assign frames_wr   = CNT_W'(0);
  assign frames_rd   = CNT_W'(0);
  assign frames_drop = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fft_res_buf_ctrl.sv
// Directed bench for fft_res_buf_ctrl: FRAME_LEN=8, L=4, rd_latency=1.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fft_res_buf_ctrl;

`ifdef FFT_RES_FRAME_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic       clk_fft = 1'b0;
  logic       reset;
  logic       sop, ena, rdy, clr;
  logic       wren, rden, valid, osop, oeop, ovf, sherr;
  logic [3:0] wadd, radd;
  logic [1:0] full;
  logic [15:0] f_wr, f_rd, f_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk_fft = ~clk_fft;

  fft_res_buf_ctrl #(
    .transform_length(16), .log2_transform_length(4), .rd_latency(1)
  ) dut (
    .clk_fft(clk_fft), .reset(reset),
    .master_source_sop(sop), .master_source_ena(ena),
    .out_ready(rdy), .clear_err(clr),
    .mram_wren(wren), .mram_writeadd(wadd),
    .mram_rden(rden), .mram_readadd(radd),
    .out_valid(valid), .out_sop(osop), .out_eop(oeop),
    .bank_full(full), .overflow_err(ovf), .short_frame_err(sherr),
    .frames_wr(f_wr), .frames_rd(f_rd), .frames_drop(f_drop)
  );

  typedef struct {
    logic       sop, ena, rdy;
    logic       wren;
    logic [3:0] wadd;
    logic       rden;
    logic [3:0] radd;
    logic       valid, osop, oeop;
    logic [1:0] full;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mkv(input logic s, e, r, we, input logic [3:0] wa,
                               input logic re, input logic [3:0] ra,
                               input logic v, os, oe, input logic [1:0] f);
    vec_t x;
    x.sop = s; x.ena = e; x.rdy = r; x.wren = we; x.wadd = wa;
    x.rden = re; x.radd = ra; x.valid = v; x.osop = os; x.oeop = oe; x.full = f;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_fft);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; sop = 1'b0; ena = 1'b0; rdy = 1'b0; clr = 1'b0;
    next_cycle();
    reset = 1'b0;
  endtask

  // Present one frame of n ena cycles with sop on the first; check write strobe/address
  task automatic wr_frame(input int n, input logic exp_wr, input logic [3:0] base,
                          input logic clr_first, input string tag);
    for (int i = 0; i < n; i++) begin
      sop = (i == 0); ena = 1'b1; clr = clr_first && (i == 0);
      @(negedge clk_fft);
      chk($sformatf("%s wren[%0d]", tag, i), 32'(wren), 32'(exp_wr));
      if (exp_wr) chk($sformatf("%s wadd[%0d]", tag, i), 32'(wadd), 32'(base + 4'(i)));
      next_cycle();
    end
    sop = 1'b0; ena = 1'b0; clr = 1'b0;
  endtask

  // Drain a single full bank with out_ready held high; expect 8 words starting at base
  task automatic drain(input logic [3:0] base, input string tag);
    int nr = 0, nv = 0, ns = 0, ne = 0;
    rdy = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk_fft);
      if (rden) begin
        chk($sformatf("%s radd[%0d]", tag, nr), 32'(radd), 32'(base + 4'(nr)));
        nr++;
      end
      if (valid) nv++;
      if (osop) ns++;
      if (oeop) ne++;
      next_cycle();
    end
    rdy = 1'b0;
    chk({tag, " valid count"}, 32'(nv), 32'd8);
    chk({tag, " sop count"}, 32'(ns), 32'd1);
    chk({tag, " eop count"}, 32'(ne), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, nvalid, prev_off;
    logic prev_r, fin, exp_rden;

    // Test 1 table: single frame written then read with out_ready high
    tbl[0] = mkv(1, 1, 1, 1, 4'd0, 0, 4'd0, 0, 0, 0, 2'b00);
    for (int i = 1; i < 8; i++)
      tbl[i] = mkv(0, 1, 1, 1, 4'(i), 0, 4'd0, 0, 0, 0, 2'b00);
    tbl[8] = mkv(0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'b01);
    for (int k = 0; k < 8; k++)
      tbl[9+k] = mkv(0, 0, 1, 0, 4'd0, 1, 4'(k), k > 0, k == 1, 0, 2'b01);
    tbl[17] = mkv(0, 0, 1, 0, 4'd0, 0, 4'd0, 1, 0, 1, 2'b00);
    tbl[18] = mkv(0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'b00);

    do_reset();
    @(negedge clk_fft);
    chk("reset wren", 32'(wren), 0);
    chk("reset rden", 32'(rden), 0);
    chk("reset valid", 32'({valid, osop, oeop}), 0);
    chk("reset full", 32'(full), 0);
    chk("reset errs", 32'({ovf, sherr}), 0);
    chk("reset cnts", {f_wr, f_rd | f_drop}, 0);
    next_cycle();

    for (int i = 0; i < 19; i++) begin
      sop = tbl[i].sop; ena = tbl[i].ena; rdy = tbl[i].rdy;
      @(negedge clk_fft);
      chk($sformatf("t1[%0d] wren", i), 32'(wren), 32'(tbl[i].wren));
      if (tbl[i].wren) chk($sformatf("t1[%0d] wadd", i), 32'(wadd), 32'(tbl[i].wadd));
      chk($sformatf("t1[%0d] rden", i), 32'(rden), 32'(tbl[i].rden));
      if (tbl[i].rden) chk($sformatf("t1[%0d] radd", i), 32'(radd), 32'(tbl[i].radd));
      chk($sformatf("t1[%0d] valid", i), 32'(valid), 32'(tbl[i].valid));
      chk($sformatf("t1[%0d] sop", i), 32'(osop), 32'(tbl[i].osop));
      chk($sformatf("t1[%0d] eop", i), 32'(oeop), 32'(tbl[i].oeop));
      chk($sformatf("t1[%0d] full", i), 32'(full), 32'(tbl[i].full));
      next_cycle();
    end
    sop = 0; ena = 0; rdy = 0;

    // Test 2: three back-to-back frames with no reads; the third is dropped
    do_reset();
    wr_frame(8, 1'b1, 4'd0, 1'b0, "t2 f0");
    wr_frame(8, 1'b1, 4'd8, 1'b0, "t2 f1");
    wr_frame(8, 1'b0, 4'd0, 1'b0, "t2 f2");
    @(negedge clk_fft);
    chk("t2 full", 32'(full), 32'b11);
    chk("t2 overflow", 32'(ovf), 1);
    chk("t2 short", 32'(sherr), 0);
    chk("t2 frames_wr", 32'(f_wr), 32'(2 * CNT_EN));
    chk("t2 frames_drop", 32'(f_drop), 32'(CNT_EN));
    next_cycle();

    // Test 3: out_ready toggling 1010.. while bank 0 drains
    cnt = 0; nvalid = 0; prev_off = 0; prev_r = 1'b0; fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      rdy = (c % 2 == 0);
      @(negedge clk_fft);
      exp_rden = (cnt < 8) && rdy;
      chk($sformatf("t3[%0d] rden", c), 32'(rden), 32'(exp_rden));
      if (exp_rden) chk($sformatf("t3[%0d] radd", c), 32'(radd), 32'(cnt));
      chk($sformatf("t3[%0d] valid", c), 32'(valid), 32'(prev_r));
      chk($sformatf("t3[%0d] sop", c), 32'(osop), 32'(prev_r && prev_off == 0));
      chk($sformatf("t3[%0d] eop", c), 32'(oeop), 32'(prev_r && prev_off == 7));
      if (valid) nvalid++;
      if (prev_r && prev_off == 7) fin = 1'b1;
      prev_r = exp_rden;
      prev_off = cnt;
      if (exp_rden) cnt++;
      next_cycle();
    end
    rdy = 1'b0;
    @(negedge clk_fft);
    chk("t3 finished", 32'(fin), 1);
    chk("t3 valid count", 32'(nvalid), 8);
    chk("t3 full", 32'(full), 32'b10);
    chk("t3 frames_rd", 32'(f_rd), 32'(CNT_EN));
    next_cycle();

    // Test 4: early sop at offset 5 restarts the frame in the same bank
    do_reset();
    wr_frame(5, 1'b1, 4'd0, 1'b0, "t4 part");
    @(negedge clk_fft);
    chk("t4 short before", 32'(sherr), 0);
    chk("t4 full before", 32'(full), 0);
    next_cycle();
    wr_frame(8, 1'b1, 4'd0, 1'b0, "t4 full");
    @(negedge clk_fft);
    chk("t4 short", 32'(sherr), 1);
    chk("t4 full", 32'(full), 32'b01);
    chk("t4 frames_wr", 32'(f_wr), 32'(CNT_EN));
    next_cycle();
    drain(4'd0, "t4 rd");
    @(negedge clk_fft);
    chk("t4 full after", 32'(full), 0);
    next_cycle();
    clr = 1'b1;
    next_cycle();
    clr = 1'b0;
    @(negedge clk_fft);
    chk("t4 short cleared", 32'(sherr), 0);
    next_cycle();

    // Test 5: synchronous reset while reading offset 4 with both banks full
    do_reset();
    wr_frame(8, 1'b1, 4'd0, 1'b0, "t5 f0");
    wr_frame(8, 1'b1, 4'd8, 1'b0, "t5 f1");
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    reset = 1'b1;
    @(negedge clk_fft);
    chk("t5 pre rden", 32'(rden), 1);
    chk("t5 pre radd", 32'(radd), 4);
    chk("t5 pre full", 32'(full), 32'b11);
    next_cycle();
    reset = 1'b0; rdy = 1'b0;
    @(negedge clk_fft);
    chk("t5 post wren/rden", 32'({wren, rden}), 0);
    chk("t5 post addrs", 32'({wadd, radd}), 0);
    chk("t5 post framing", 32'({valid, osop, oeop}), 0);
    chk("t5 post full", 32'(full), 0);
    chk("t5 post cnts", {f_wr, f_rd | f_drop}, 0);
    next_cycle();
    wr_frame(8, 1'b1, 4'd0, 1'b0, "t5 new");
    drain(4'd0, "t5 rd");
    @(negedge clk_fft);
    chk("t5 full after", 32'(full), 0);
    chk("t5 frames_rd", 32'(f_rd), 32'(CNT_EN));
    next_cycle();

    // Test 6: clear_err in the same cycle as a new drop, then a later drop
    do_reset();
    wr_frame(8, 1'b1, 4'd0, 1'b0, "t6 f0");
    wr_frame(8, 1'b1, 4'd8, 1'b0, "t6 f1");
    wr_frame(8, 1'b0, 4'd0, 1'b0, "t6 d0");
    @(negedge clk_fft);
    chk("t6 ovf first", 32'(ovf), 1);
    next_cycle();
    wr_frame(1, 1'b0, 4'd0, 1'b1, "t6 d1");
    @(negedge clk_fft);
    chk("t6 ovf cleared", 32'(ovf), 0);
    next_cycle();
    wr_frame(8, 1'b0, 4'd0, 1'b0, "t6 d2");
    @(negedge clk_fft);
    chk("t6 ovf again", 32'(ovf), 1);
    chk("t6 frames_drop", 32'(f_drop), 32'(3 * CNT_EN));
    chk("t6 frames_wr", 32'(f_wr), 32'(2 * CNT_EN));
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
